tdc_fine_encoder_pipe: RTL and testbench

Parametrised, pipelined fine-phase encoder for the TOA/TOT TDC path. Converts an NPHASE-bit sample of an inverting delay-line ring into a (BW+1)-bit binary fine code. Applies median-based bubble correction with a programmable tolerance level, flags every bubble event, and optionally counts errors. Sits between the TDC sample flops and the coarse/fine combiner.

---
 rtl/tdc_fine_encoder_pipe_if.sv | 24 ++
 rtl/tdc_fine_encoder_pipe.sv | 152 +++++++++++++++
 tb/tb_tdc_fine_encoder_pipe.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_fine_encoder_pipe_if.sv
// Sample/result bundle between the TDC sample flops and the fine encoder.
// master drives samples and observes results; slave is the encoder side.
interface tdc_fine_encoder_pipe_if #(
   parameter int NPHASE = 63
);
   localparam int BW = $clog2(NPHASE);

   logic              in_valid;
   logic [NPHASE-1:0] code_in;
   logic [2:0]        level;
   logic              out_valid;
   logic [BW:0]       fine_out;
   logic [1:0]        bubble_err;

   modport master (
      output in_valid, code_in, level,
      input  out_valid, fine_out, bubble_err
   );

   modport slave (
      input  in_valid, code_in, level,
      output out_valid, fine_out, bubble_err
   );
endinterface

// File: rtl/tdc_fine_encoder_pipe.sv
// Pipelined ring-sample to {msb, position} fine encoder with median bubble correction.
// Define TDC_FINE_ERRCNT_EN to build the saturating corrected/uncorrectable error counters.
module tdc_fine_encoder_pipe #(
   parameter int NPHASE = 63,
   parameter int CNTW   = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   tdc_fine_encoder_pipe_if.slave io,
   input  logic                   cnt_clr,
   output logic [CNTW-1:0]        corr_cnt,
   output logic [CNTW-1:0]        uncorr_cnt
);
   localparam int BW     = $clog2(NPHASE);
   localparam int PW     = $clog2(NPHASE + 1);
   // one spare bit so pop+1 cannot wrap; at least 4 bits to hold maxpop = 13
   localparam int CW     = (PW + 1 > 4) ? PW + 1 : 4;
   localparam int STAGES = 4;

   localparam logic [1:0] ERR_CLEAN = 2'b00;
   localparam logic [1:0] ERR_CORR  = 2'b01;
   localparam logic [1:0] ERR_UNCOR = 2'b10;

   typedef struct packed {
      logic [NPHASE-1:0] d;
      logic              msb;
      logic [CW-1:0]     maxpop;
   } s1_t;

   typedef struct packed {
      logic [NPHASE-1:0] d;
      logic              msb;
      logic [CW-1:0]     maxpop;
      logic [CW-1:0]     pop;
   } s2_t;

   typedef struct packed {
      logic [BW-1:0]     pos;
      logic              msb;
      logic [CW-1:0]     maxpop;
      logic [CW-1:0]     pop;
   } s3_t;

   logic [STAGES:1]   vld_pipe;
   logic [NPHASE-1:0] edge_vec;
   logic [2:0]        lvl_eff;
   s1_t               s1_d, s1_q;
   s2_t               s2_d, s2_q;
   s3_t               s3_d, s3_q;
   logic [CW-1:0]     k_sel, seen;
   logic [BW:0]       fine_d;
   logic [1:0]        err_d;

   // bit 0 compares across the inverting wrap of the ring, hence XNOR
   assign edge_vec[0] = ~(io.code_in[0] ^ io.code_in[NPHASE-1]);
   for (genvar i = 1; i < NPHASE; i++) begin : g_edge
      assign edge_vec[i] = io.code_in[i] ^ io.code_in[i-1];
   end

   assign lvl_eff = (io.level == 3'd0) ? 3'd1 : io.level;

   always_comb begin
      s1_d.d      = edge_vec;
      s1_d.msb    = ~io.code_in[NPHASE-1];
      s1_d.maxpop = CW'({lvl_eff, 1'b0} - 4'd1);
   end

   always_comb begin
      s2_d.d      = s1_q.d;
      s2_d.msb    = s1_q.msb;
      s2_d.maxpop = s1_q.maxpop;
      s2_d.pop    = '0;
      for (int i = 0; i < NPHASE; i++) s2_d.pop = s2_d.pop + CW'(s1_q.d[i]);
   end

   // k-th set edge from bit 0; k = 1 for a clean code, lower median otherwise
   always_comb begin
      k_sel       = (s2_q.pop + CW'(1)) >> 1;
      seen        = '0;
      s3_d.pos    = '0;
      s3_d.msb    = s2_q.msb;
      s3_d.maxpop = s2_q.maxpop;
      s3_d.pop    = s2_q.pop;
      for (int i = 0; i < NPHASE; i++) begin
         if (s2_q.d[i]) begin
            seen = seen + CW'(1);
            if (seen == k_sel) s3_d.pos = BW'(i);
         end
      end
   end

   always_comb begin
      fine_d = {s3_q.msb, s3_q.pos};
      err_d  = ERR_CLEAN;
      if (s3_q.pop == CW'(1)) begin
         err_d = ERR_CLEAN;
      end else if (s3_q.pop != '0 && s3_q.pop <= s3_q.maxpop) begin
         err_d = ERR_CORR;
      end else begin
         fine_d = '1;
         err_d  = ERR_UNCOR;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_pipe <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], io.in_valid};
         if (io.in_valid)  s1_q <= s1_d;
         if (vld_pipe[1])  s2_q <= s2_d;
         if (vld_pipe[2])  s3_q <= s3_d;
      end
   end

   // result fields hold between strobes
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         io.fine_out   <= '0;
         io.bubble_err <= '0;
      end else if (vld_pipe[STAGES-1]) begin
         io.fine_out   <= fine_d;
         io.bubble_err <= err_d;
      end
   end

   assign io.out_valid = vld_pipe[STAGES];

`ifdef TDC_FINE_ERRCNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (vld_pipe[STAGES-1]) begin
         if (err_d == ERR_CORR && corr_cnt != '1)    corr_cnt   <= corr_cnt + CNTW'(1);
         if (err_d == ERR_UNCOR && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNTW'(1);
      end
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign corr_cnt       = '0;
   assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_tdc_fine_encoder_pipe.sv
// Scoreboard bench for tdc_fine_encoder_pipe: stimulus pushes expected results, a monitor pops on out_valid.
// Counter expectations follow TDC_FINE_ERRCNT_EN (counters tied to 0 when it is undefined).
module tb_tdc_fine_encoder_pipe;
   localparam int NPHASE = 63;
   localparam int CNTW   = 2;
   localparam int CMAX   = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            cnt_clr = 1'b0;
   logic [CNTW-1:0] corr_cnt, uncorr_cnt;
   int              tests = 0;
   int              fails = 0;
   int              cyc = 0;

   typedef struct {
      logic [6:0] fine;
      logic [1:0] err;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];

   tdc_fine_encoder_pipe_if #(.NPHASE(NPHASE)) io ();

   tdc_fine_encoder_pipe #(.NPHASE(NPHASE), .CNTW(CNTW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .io         (io),
      .cnt_clr    (cnt_clr),
      .corr_cnt   (corr_cnt),
      .uncorr_cnt (uncorr_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // reference: list the ring edges, pick by the tolerance rules
   function automatic exp_t model(input logic [62:0] c, input logic [2:0] lv);
      exp_t e;
      int   idx[$];
      int   l;
      bit   msb;
      l   = (lv == 0) ? 1 : int'(lv);
      msb = !c[62];
      for (int i = 0; i < NPHASE; i++) begin
         if (i == 0) begin
            if (c[0] == c[62]) idx.push_back(i);
         end else if (c[i] != c[i-1]) begin
            idx.push_back(i);
         end
      end
      e.cyc = 0;
      if (idx.size() == 1) begin
         e.fine = {msb, 6'(idx[0])};
         e.err  = 2'b00;
      end else if (idx.size() >= 2 && idx.size() <= 2 * l - 1) begin
         e.fine = {msb, 6'(idx[(idx.size() + 1) / 2 - 1])};
         e.err  = 2'b01;
      end else begin
         e.fine = 7'h7F;
         e.err  = 2'b10;
      end
      return e;
   endfunction

   function automatic logic [62:0] rand_code();
      logic [62:0] c, one;
      int p, n, b;
      one = 63'd1;
      if ($urandom_range(0, 9) == 0) return 63'({$urandom(), $urandom()});
      p = int'($urandom_range(0, 63));
      c = (p == 63) ? '1 : (one << p) - one;
      if ($urandom_range(0, 1) == 1) c = ~c;
      n = int'($urandom_range(0, 3));
      repeat (n) begin
         b = p + int'($urandom_range(0, 6)) - 3;
         if (b >= 0 && b < NPHASE) c[b] = ~c[b];
      end
      return c;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [62:0] c, input logic [2:0] lv, input exp_t e);
      e.cyc = cyc + 4;
      exp_q.push_back(e);
      io.in_valid = 1'b1;
      io.code_in  = c;
      io.level    = lv;
      @(posedge clk);
      #1;
      io.in_valid = 1'b0;
   endtask

   task automatic issue(input logic [62:0] c, input logic [2:0] lv);
      send(c, lv, model(c, lv));
   endtask

   task automatic issue_x(input logic [62:0] c, input logic [2:0] lv,
                          input logic [6:0] fine, input logic [1:0] err);
      exp_t e;
      e.fine = fine;
      e.err  = err;
      e.cyc  = 0;
      send(c, lv, e);
   endtask

   task automatic chk_cnt(input string name, input int c_exp, input int u_exp);
`ifdef TDC_FINE_ERRCNT_EN
      chk({name, "_corr"}, 32'(corr_cnt), 32'(c_exp));
      chk({name, "_uncorr"}, 32'(uncorr_cnt), 32'(u_exp));
`else
      chk({name, "_corr"}, 32'(corr_cnt), 32'(c_exp * 0));
      chk({name, "_uncorr"}, 32'(uncorr_cnt), 32'(u_exp * 0));
`endif
   endtask

   // monitor: pops on every strobe, checks hold behaviour and tracks counters
   initial begin
      exp_t       e;
      logic       clr_s;
      logic [6:0] lf;
      logic [1:0] le;
      int         mc, mu;
      bit         got;
      lf = '0; le = '0; mc = 0; mu = 0;
      forever begin
         @(posedge clk);
         clr_s = cnt_clr;
         @(negedge clk);
         got = 1'b0;
         if (!rstn) begin
            mc = 0; mu = 0; lf = '0; le = '0;
         end
         if (io.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 32'(io.out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               got = 1'b1;
               chk("fine_out", 32'(io.fine_out), 32'(e.fine));
               chk("bubble_err", 32'(io.bubble_err), 32'(e.err));
               chk("latency", 32'(cyc), 32'(e.cyc));
               lf = e.fine;
               le = e.err;
            end
         end else begin
            chk("hold_fine", 32'(io.fine_out), 32'(lf));
            chk("hold_err", 32'(io.bubble_err), 32'(le));
         end
         if (rstn) begin
            if (clr_s) begin
               mc = 0; mu = 0;
            end else if (got) begin
               if (e.err == 2'b01 && mc < CMAX) mc++;
               if (e.err == 2'b10 && mu < CMAX) mu++;
            end
         end
         chk_cnt("mon_cnt", mc, mu);
      end
   end

   initial begin
      logic [62:0] ones;
      int          n;
      ones        = '1;
      io.in_valid = 1'b0;
      io.code_in  = '0;
      io.level    = 3'd0;

      idle(3);
      chk("rst_out_valid", 32'(io.out_valid), 32'd0);
      chk("rst_fine", 32'(io.fine_out), 32'd0);
      chk("rst_err", 32'(io.bubble_err), 32'd0);
      chk_cnt("rst_cnt", 0, 0);
      rstn = 1'b1;
      idle(2);

      // clean, wrap and bubble cases back to back
      issue_x(63'hF, 3'd1, 7'h44, 2'b00);
      issue_x(ones, 3'd1, 7'h00, 2'b00);
      issue_x(63'h0, 3'd3, 7'h40, 2'b00);
      issue_x(63'h2F, 3'd2, 7'h45, 2'b01);
      issue_x(63'h2F, 3'd1, 7'h7F, 2'b10);
      issue_x(63'h2F, 3'd0, 7'h7F, 2'b10);
      idle(5);

      for (int i = 0; i < 10; i++) issue(rand_code(), 3'($urandom_range(0, 7)));
      idle(5);

      // counter saturation, then clear landing on an error result
      cnt_clr = 1'b1;
      idle(1);
      cnt_clr = 1'b0;
      repeat (3) issue_x(63'h2F, 3'd2, 7'h45, 2'b01);
      repeat (5) issue_x(63'h2F, 3'd1, 7'h7F, 2'b10);
      idle(5);
      chk_cnt("sat_cnt", 3, 3);
      issue_x(63'h2F, 3'd1, 7'h7F, 2'b10);
      idle(2);
      cnt_clr = 1'b1;
      idle(1);
      cnt_clr = 1'b0;
      chk_cnt("clr_vs_inc", 0, 0);
      idle(3);

      // reset with three samples in flight
      issue_x(63'h2F, 3'd2, 7'h45, 2'b01);
      idle(4);
      chk_cnt("pre_rst_cnt", 1, 0);
      issue(rand_code(), 3'd3);
      issue(rand_code(), 3'd3);
      issue(rand_code(), 3'd3);
      rstn = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
      chk("midrst_fine", 32'(io.fine_out), 32'd0);
      chk("midrst_err", 32'(io.bubble_err), 32'd0);
      chk_cnt("midrst_cnt", 0, 0);
      idle(2);
      rstn = 1'b1;
      idle(6);
      issue_x(63'hF, 3'd1, 7'h44, 2'b00);
      idle(5);

      // randomized traffic with gaps and occasional clears
      for (int i = 0; i < 400; i++) begin
         cnt_clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) != 0) issue(rand_code(), 3'($urandom_range(0, 7)));
         else idle(1);
      end
      cnt_clr = 1'b0;

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         idle(1);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
